// File: rtl/game_period_sequencer.sv
// ---------------------------------------------------------------------------
// game_period_sequencer
//
// Purpose:
//   Steps one game round through the prelim, game, answer and post periods.
//   Each period is timed in one-second ticks derived from a prescaled clock.
//   A one-cycle entry strobe is issued per period for the current-period
//   latch. The seconds remaining in the current period are exported for the
//   display. The answer period can end early on answerDone. abortReq returns
//   the block to IDLE from any state.
//
// Optional feature (macro SEQ_PAUSE_EN):
//   When defined, a `pause` input is added. While it is high, the prescaler
//   and secLeft hold and no tick is generated. answerDone, abortReq and
//   startReq still act while paused.
//
// Parameters:
//   TICK_DIV    Clk100M cycles per one-second tick (>= 2)
//   PRELIM_SECS prelim period length in ticks (1..255)
//   GAME_SECS   game period length in ticks (1..255)
//   ANSWER_SECS answer timeout in ticks (1..255)
//   POST_SECS   post period length in ticks (1..255)
//
// Ports:
//   Clk100M    in   system clock
//   RstN       in   asynchronous active-low reset
//   startReq   in   starts a round (sampled only in IDLE)
//   answerDone in   ends the answer period early (ANSWER only)
//   abortReq   in   returns to IDLE from any state; highest priority
//   pause      in   freezes timing (only with SEQ_PAUSE_EN)
//   prelimSig  out  one-cycle strobe on entry to PRELIM
//   gameSig    out  one-cycle strobe on entry to GAME
//   answerSig  out  one-cycle strobe on entry to ANSWER
//   postSig    out  one-cycle strobe on entry to POST
//   busy       out  high in every state except IDLE
//   secLeft    out  ticks remaining in the current period, 0 in IDLE
// ---------------------------------------------------------------------------
module game_period_sequencer #(
  parameter int unsigned TICK_DIV    = 100000000,
  parameter int unsigned PRELIM_SECS = 5,
  parameter int unsigned GAME_SECS   = 30,
  parameter int unsigned ANSWER_SECS = 10,
  parameter int unsigned POST_SECS   = 5
) (
  input  logic       Clk100M,
  input  logic       RstN,
  input  logic       startReq,
  input  logic       answerDone,
  input  logic       abortReq,
`ifdef SEQ_PAUSE_EN
  input  logic       pause,
`endif
  output logic       prelimSig,
  output logic       gameSig,
  output logic       answerSig,
  output logic       postSig,
  output logic       busy,
  output logic [7:0] secLeft
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  localparam logic [7:0] PRELIM_LOAD = 8'(PRELIM_SECS);
  localparam logic [7:0] GAME_LOAD   = 8'(GAME_SECS);
  localparam logic [7:0] ANSWER_LOAD = 8'(ANSWER_SECS);
  localparam logic [7:0] POST_LOAD   = 8'(POST_SECS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRELIM,
    S_GAME,
    S_ANSWER,
    S_POST
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    sec_q,   sec_d;
  // Entry strobes packed as {prelim, game, answer, post}.
  logic [3:0]    strobe_q, strobe_d;
  logic          busy_q,   busy_d;

  logic run;
  logic tick;
  logic expire;

`ifdef SEQ_PAUSE_EN
  assign run = ~pause;
`else
  assign run = 1'b1;
`endif

  // A tick is the cycle in which the prescaler wraps back to 0.
  assign tick   = run && (state_q != S_IDLE) && (presc_q == PRESC_MAX);
  // Final tick of a period: leave the state instead of decrementing to 0.
  assign expire = tick && (sec_q == 8'd1);

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    sec_d    = sec_q;
    strobe_d = 4'b0000;

    // Free-running prescaler and countdown inside a timed state.
    if ((state_q != S_IDLE) && run) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick && (sec_q > 8'd1)) begin
        sec_d = sec_q - 8'd1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (startReq) begin
          state_d  = S_PRELIM;
          sec_d    = PRELIM_LOAD;
          presc_d  = '0;
          strobe_d = 4'b1000;
        end
      end
      S_PRELIM: begin
        if (expire) begin
          state_d  = S_GAME;
          sec_d    = GAME_LOAD;
          presc_d  = '0;
          strobe_d = 4'b0100;
        end
      end
      S_GAME: begin
        if (expire) begin
          state_d  = S_ANSWER;
          sec_d    = ANSWER_LOAD;
          presc_d  = '0;
          strobe_d = 4'b0010;
        end
      end
      S_ANSWER: begin
        // An answer and a timeout in the same cycle collapse into one entry.
        if (answerDone || expire) begin
          state_d  = S_POST;
          sec_d    = POST_LOAD;
          presc_d  = '0;
          strobe_d = 4'b0001;
        end
      end
      S_POST: begin
        if (expire) begin
          state_d = S_IDLE;
          sec_d   = 8'd0;
          presc_d = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        sec_d   = 8'd0;
        presc_d = '0;
      end
    endcase

    // Abort overrides everything above, including a start from IDLE.
    if (abortReq) begin
      state_d  = S_IDLE;
      sec_d    = 8'd0;
      presc_d  = '0;
      strobe_d = 4'b0000;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge Clk100M or negedge RstN) begin
    if (!RstN) begin
      state_q  <= S_IDLE;
      presc_q  <= '0;
      sec_q    <= 8'd0;
      strobe_q <= 4'b0000;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      sec_q    <= sec_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
    end
  end

  assign prelimSig = strobe_q[3];
  assign gameSig   = strobe_q[2];
  assign answerSig = strobe_q[1];
  assign postSig   = strobe_q[0];
  assign busy      = busy_q;
  assign secLeft   = sec_q;

endmodule

// File: tb/tb_game_period_sequencer.sv
// ---------------------------------------------------------------------------
// tb_game_period_sequencer
//
// Directed bench for game_period_sequencer with TICK_DIV=4, PRELIM_SECS=2,
// GAME_SECS=3, ANSWER_SECS=2, POST_SECS=2. Cycle c of a scenario is the
// clock period that follows rising edge c-1; inputs are driven and outputs
// sampled at the falling edge inside each cycle. The pause scenario runs
// only when SEQ_PAUSE_EN is defined.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_game_period_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start_req;
  logic       answer_done;
  logic       abort_req;
`ifdef SEQ_PAUSE_EN
  logic       pause;
`endif
  logic       prelim_sig;
  logic       game_sig;
  logic       answer_sig;
  logic       post_sig;
  logic       busy;
  logic [7:0] sec_left;

  int checks = 0;
  int errors = 0;

  game_period_sequencer #(
    .TICK_DIV   (4),
    .PRELIM_SECS(2),
    .GAME_SECS  (3),
    .ANSWER_SECS(2),
    .POST_SECS  (2)
  ) dut (
    .Clk100M   (clk),
    .RstN      (rst_n),
    .startReq  (start_req),
    .answerDone(answer_done),
    .abortReq  (abort_req),
`ifdef SEQ_PAUSE_EN
    .pause     (pause),
`endif
    .prelimSig (prelim_sig),
    .gameSig   (game_sig),
    .answerSig (answer_sig),
    .postSig   (post_sig),
    .busy      (busy),
    .secLeft   (sec_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [3:0] strobes();
    return {prelim_sig, game_sig, answer_sig, post_sig};
  endfunction

  // Start a round in the current cycle (cycle 0) and follow it for n cycles.
  // exp_* give the cycle of each strobe and of the return to IDLE (0 or a
  // cycle beyond n when that event is not expected in the window).
  task automatic run_round(input string name, input int ans_cyc,
                           input int pause_from, input int pause_to, input int n,
                           input int exp_p, input int exp_g, input int exp_a,
                           input int exp_po, input int exp_idle, input bit full_sec);
    logic [3:0] exp_s;
    start_req = 1'b1;
    for (int c = 1; c <= n; c++) begin
      step();
      start_req = 1'b0;
      exp_s = {c == exp_p, c == exp_g, c == exp_a, c == exp_po};
      check($sformatf("%s strobes c%0d", name, c), 32'(strobes()), 32'(exp_s));
      check($sformatf("%s busy c%0d", name, c), 32'(busy),
            32'((c >= exp_p) && (c < exp_idle)));
      if (c == exp_p)      check($sformatf("%s sec c%0d", name, c), 32'(sec_left), 32'd2);
      if (c == exp_p + 3)  check($sformatf("%s sec c%0d", name, c), 32'(sec_left), 32'd2);
      if (c == exp_g - 1)  check($sformatf("%s sec c%0d", name, c), 32'(sec_left), 32'd1);
      if (c == exp_g)      check($sformatf("%s sec c%0d", name, c), 32'(sec_left), 32'd3);
      if (c == exp_g + 4)  check($sformatf("%s sec c%0d", name, c), 32'(sec_left), 32'd2);
      if (c == exp_a - 1)  check($sformatf("%s sec c%0d", name, c), 32'(sec_left), 32'd1);
      if (c == exp_a)      check($sformatf("%s sec c%0d", name, c), 32'(sec_left), 32'd2);
      if (full_sec && (c == exp_po - 1))
                           check($sformatf("%s sec c%0d", name, c), 32'(sec_left), 32'd1);
      if (c == exp_po)     check($sformatf("%s sec c%0d", name, c), 32'(sec_left), 32'd2);
      if (c == exp_idle - 1) check($sformatf("%s sec c%0d", name, c), 32'(sec_left), 32'd1);
      if (c == exp_idle)   check($sformatf("%s sec c%0d", name, c), 32'(sec_left), 32'd0);
      if ((c >= pause_from) && (c <= pause_to + 1))
                           check($sformatf("%s psec c%0d", name, c), 32'(sec_left), 32'd2);
      answer_done = (c == ans_cyc);
`ifdef SEQ_PAUSE_EN
      pause = (c >= pause_from) && (c <= pause_to);
`endif
    end
    answer_done = 1'b0;
`ifdef SEQ_PAUSE_EN
    pause = 1'b0;
`endif
    $display("round %s done", name);
  endtask

  initial begin
    rst_n       = 1'b0;
    start_req   = 1'b0;
    answer_done = 1'b0;
    abort_req   = 1'b0;
`ifdef SEQ_PAUSE_EN
    pause       = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk);
    check("reset strobes", 32'(strobes()), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset sec", 32'(sec_left), 32'd0);
    rst_n = 1'b1;
    step();
    check("idle busy", 32'(busy), 32'd0);
    check("idle sec", 32'(sec_left), 32'd0);

    // Full round.
    run_round("full", -1, -1, -1, 38, 1, 9, 21, 29, 37, 1'b1);
    // Early answer in cycle 23.
    run_round("early", 23, -1, -1, 33, 1, 9, 21, 24, 32, 1'b0);
    // Answer on the timeout cycle: a single postSig at 29.
    run_round("simul", 28, -1, -1, 38, 1, 9, 21, 29, 37, 1'b1);

`ifdef SEQ_PAUSE_EN
    // Pause over cycles 3..12 pushes gameSig from 9 to 19.
    run_round("pause", -1, 3, 12, 20, 1, 19, 0, 0, 1000, 1'b0);
    abort_req = 1'b1;
    step();
    abort_req = 1'b0;
    check("pause abort busy", 32'(busy), 32'd0);
`endif

    // Abort in GAME with startReq also high.
    start_req = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      start_req = 1'b0;
      if (c == 9) check("abort gameSig c9", 32'(strobes()), 32'b0100);
    end
    abort_req = 1'b1;
    start_req = 1'b1;
    step();  // cycle 13
    check("abort busy c13", 32'(busy), 32'd0);
    check("abort sec c13", 32'(sec_left), 32'd0);
    check("abort strobes c13", 32'(strobes()), 32'd0);
    step();  // cycle 14: abort and start together in IDLE
    check("idle abort+start busy c14", 32'(busy), 32'd0);
    check("idle abort+start strobes c14", 32'(strobes()), 32'd0);
    abort_req = 1'b0;
    start_req = 1'b1;
    step();  // cycle 15
    start_req = 1'b0;
    check("restart prelim c15", 32'(strobes()), 32'b1000);
    check("restart busy c15", 32'(busy), 32'd1);
    check("restart sec c15", 32'(sec_left), 32'd2);
    abort_req = 1'b1;
    step();
    abort_req = 1'b0;
    check("abort prelim busy", 32'(busy), 32'd0);
    $display("round abort done");

    // Asynchronous reset mid-GAME at cycle 15.
    start_req = 1'b1;
    for (int c = 1; c <= 15; c++) begin
      step();
      start_req = 1'b0;
    end
    check("pre-reset busy c15", 32'(busy), 32'd1);
    check("pre-reset sec c15", 32'(sec_left), 32'd2);
    rst_n = 1'b0;
    #1;
    check("async busy", 32'(busy), 32'd0);
    check("async sec", 32'(sec_left), 32'd0);
    check("async strobes", 32'(strobes()), 32'd0);
    start_req = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("in-reset busy %0d", c), 32'(busy), 32'd0);
      check($sformatf("in-reset strobes %0d", c), 32'(strobes()), 32'd0);
    end
    start_req = 1'b0;
    rst_n = 1'b1;
    step();
    check("post-release busy", 32'(busy), 32'd0);
    start_req = 1'b1;
    step();
    start_req = 1'b0;
    check("post-release prelim", 32'(strobes()), 32'b1000);
    check("post-release sec", 32'(sec_left), 32'd2);
    $display("round reset done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_period_sequencer.md
# game_period_sequencer

Drives the four period-entry strobes (`prelimSig`, `gameSig`, `answerSig`, `postSig`) that feed the current-period latch. A round is one pass of prelim, game, answer and post periods. Each period is timed in seconds from a prescaled 100 MHz clock. The answer period can end early on a player answer. The block also exports the seconds remaining, for the display.

## Interface
- `TICK_DIV`, default 100000000: `Clk100M` cycles per one-second tick; minimum 2.
- `PRELIM_SECS`, default 5: prelim period length in ticks; range 1..255.
- `GAME_SECS`, default 30: game period length in ticks; range 1..255.
- `ANSWER_SECS`, default 10: answer timeout in ticks; range 1..255.
- `POST_SECS`, default 5: post period length in ticks; range 1..255.

Ports:
- `Clk100M`  in  1  system clock, 100 MHz.
- `RstN`  in  1  asynchronous, active-low reset.
- `startReq`  in  1  level or pulse; starts a round; sampled only in IDLE.
- `answerDone`  in  1  pulse; ends the answer period early; ignored in all other states.
- `abortReq`  in  1  returns to IDLE from any state.
- `pause`  in  1  freezes timing; present only with `SEQ_PAUSE_EN`.
- `prelimSig`  out  1  one-cycle strobe on entry to the prelim period.
- `gameSig`  out  1  one-cycle strobe on entry to the game period.
- `answerSig`  out  1  one-cycle strobe on entry to the answer period.
- `postSig`  out  1  one-cycle strobe on entry to the post period.
- `busy`  out  1  high in every state except IDLE.
- `secLeft`  out  8  ticks remaining in the current period; 0 in IDLE.

## Operation
- States: IDLE, PRELIM, GAME, ANSWER, POST.
- Reset (`RstN` low): immediately go to IDLE. All strobes 0, `busy` 0, `secLeft` 0, prescaler 0.
- IDLE to PRELIM: on `startReq` high. `startReq` in any other state has no effect.
- PRELIM to GAME, GAME to ANSWER, POST to IDLE: on a tick while `secLeft` == 1.
- ANSWER to POST: on `answerDone`, or on a tick while `secLeft` == 1. If both occur in the same cycle, take one transition and issue one `postSig`.
- Entering a timed state:
  - load `secLeft` with that state's `*_SECS` value;
  - clear the prescaler;
  - pulse that state's strobe for one cycle.
- Inside a timed state:
  - the prescaler counts 0..`TICK_DIV`-1; a tick is the cycle it wraps to 0;
  - a tick with `secLeft` > 1 decrements `secLeft`.
- POST to IDLE: no strobe; `secLeft` goes to 0; `busy` falls.
- `abortReq`:
  - in any non-IDLE state: go to IDLE with no strobe; `secLeft` goes to 0.
  - priority over every timeout, `answerDone` and `startReq` in the same cycle.
  - in IDLE: `abortReq` and `startReq` together leave the block in IDLE.
- Strobes are mutually exclusive; at most one is high in any cycle.
- Arithmetic:
  - prescaler width is clog2(`TICK_DIV`);
  - `secLeft` never wraps below 1 inside a timed state.

## Timing
- All outputs are registered.
- Start latency: `startReq` sampled high at edge N gives `prelimSig` high in cycle N+1, and `busy` high from cycle N+1.
- Period length: the strobe of period P is high at cycle E, and the next strobe or return to IDLE occurs at cycle E + `P_SECS`*`TICK_DIV`.
- Answer latency: `answerDone` sampled at edge N gives `postSig` in cycle N+1.
- Abort latency: `abortReq` sampled at edge N gives IDLE and `busy` low in cycle N+1.
- `secLeft` changes on the cycle after the tick.

## Configuration
- `SEQ_PAUSE_EN` defined:
  - adds the `pause` port;
  - while `pause` is high, the prescaler and `secLeft` hold and no tick is generated;
  - `answerDone` and `abortReq` still act while paused;
  - `startReq` in IDLE still acts; the new round is frozen from entry.
- `SEQ_PAUSE_EN` undefined: no `pause` port; timing never stops.

## Test plan
All scenarios use `TICK_DIV`=4, `PRELIM_SECS`=2, `GAME_SECS`=3, `ANSWER_SECS`=2, `POST_SECS`=2.

- Full round: start at edge 0 -> `prelimSig` at cycle 1, `gameSig` at 9, `answerSig` at 21, `postSig` at 29; `busy` low and `secLeft` 0 at 37.
- Early answer: `answerDone` at cycle 23 -> `postSig` at 24, IDLE at 32.
- Simultaneous: `answerDone` on the answer-timeout cycle -> exactly one `postSig`, at 29.
- Abort: `abortReq` at cycle 12 with `startReq` also high -> IDLE at 13, no strobes; `startReq` at 14 -> `prelimSig` at 15.
- Async reset: `RstN` low at cycle 15 mid-GAME -> all outputs 0 immediately, before the next edge; `startReq` ignored until release.
- `SEQ_PAUSE_EN`: `pause` high for cycles 3..12 -> `secLeft` holds 2 and `gameSig` moves from 9 to 19.
